// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// The fetch queue stores {instr, pc_plus4} pairs; an empty queue presents
// an all-zero word, which decodes as a MIPS NOP (sll $0,$0,0).
package fetch_pkg;

    localparam int INSTR_W      = 32;
    localparam int FETCH_ADDR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One fetched instruction together with the address of its successor.
    typedef struct packed {
        logic [INSTR_W-1:0]      instr;
        logic [FETCH_ADDR_W-1:0] pc_plus4;
    } fetch_entry_t;

    // Sequential successor of a word-aligned PC; wraps modulo 2^FETCH_ADDR_W.
    function automatic logic [FETCH_ADDR_W-1:0] next_pc(input logic [FETCH_ADDR_W-1:0] pc);
        return pc + FETCH_ADDR_W'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries between IF and ID.
// Storage is a bank of registers (one per slot) so the head is available
// combinationally from flops. clear beats push and pop in the same cycle.
// DEPTH must be a power of two so the pointers wrap without compare logic.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   clear,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic   do_push;
    logic   do_pop;
    entry_t slot_view [DEPTH];

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign head  = slot_view[rd_ptr_q];

    // Qualify the requests: a pop needs data, a push needs room unless the
    // head leaves in the same cycle, and a clear suppresses both.
    always_comb begin
        do_pop  = pop && !empty && !clear;
        do_push = push && !clear && (!full || do_pop);
    end

    // Pointer and occupancy update; clear empties the queue in one cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // One register per slot. Slot contents need no reset: the consumer
    // masks the head whenever the queue is empty.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        entry_t slot_q;
        entry_t slot_d;

        // Capture the incoming entry only when this slot is the write target.
        always_comb begin
            slot_d = slot_q;
            if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                slot_d = din;
            end
        end

        // Slot storage register.
        always_ff @(posedge clk) begin
            slot_q <= slot_d;
        end

        assign slot_view[gi] = slot_q;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the instruction-memory
// address, queues {instr, pc+4} pairs for decode, and accepts redirects
// from EX/MEM that flush every younger fetch.
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetch_cnt (pushes) and
// perf_stall_cnt (cycles with id_valid & !id_ready).
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // Queue entry sized for this instance's address width.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
    } entry_t;

    // The PC is kept word aligned even if RESET_PC carries low bits.
    localparam logic [ADDR_W-1:0] RESET_PC_ALIGNED = {RESET_PC[ADDR_W-1:2], 2'b00};

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] redirect_target;

    logic   push;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;
    entry_t fifo_din;
    entry_t fifo_head;

    // The two low bits of a redirect target are dropped by design.
    logic redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imem_addr       = pc_q;

    // Use the shared successor helper when widths line up; otherwise a
    // plain add of the same meaning.
    if (ADDR_W == FETCH_ADDR_W) begin : g_pc_inc_pkg
        assign pc_plus4 = next_pc(pc_q);
    end else begin : g_pc_inc_generic
        assign pc_plus4 = pc_q + ADDR_W'(4);
    end

    // Handshake: decode pops the head; fetch pushes unless a redirect is
    // flushing the pipe or the queue is full with no pop to make room.
    always_comb begin
        pop      = id_valid && id_ready;
        push     = !redirect_valid && (!fifo_full || pop);
        fifo_din = '{instr: imem_rdata, pc_plus4: pc_plus4};
    end

    // Next PC: a redirect wins, otherwise advance only when the fetch is
    // accepted into the queue, so imem_addr stays put while stalled.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (push) begin
            pc_d = pc_plus4;
        end
    end

    // PC register; reset overrides redirect and stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC_ALIGNED;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Present the registered head; an empty queue shows a NOP at PC+4 = 0.
    always_comb begin
        id_valid    = !fifo_empty;
        id_instr    = NOP_INSTR;
        id_pc_plus4 = '0;
        if (!fifo_empty) begin
            id_instr    = fifo_head.instr;
            id_pc_plus4 = fifo_head.pc_plus4;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_fetch_d;
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;

    // Counters free-run across redirects and wrap at 2^32.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        if (push) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (id_valid && !id_ready) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. The stimulus process queues the
// instructions decode is expected to receive, in order; a monitor on the
// falling edge pops and compares every accepted head entry.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   txn_n  = 0;

    if_fetch_unit #(
        .ADDR_W     (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc_plus4    (id_pc_plus4)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Instruction memory contents: addi $t0,$zero,1 at 0, a distinct tag elsewhere.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0001;
        return 32'h8C00_0000 ^ a;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back('{instr: imem_word(pc), pc_plus4: pc + 32'd4});
    endtask

    // Monitor: one transaction per accepted head entry (redirect discards the pop).
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1 && redirect_valid === 1'b0) begin
            checks++;
            txn_n++;
            if (exp_q.size() == 0) begin
                $display("FAIL txn %0d unexpected: pc_plus4=0x%08h instr=0x%08h, expected no entry",
                         txn_n, id_pc_plus4, id_instr);
            end else begin
                e = exp_q.pop_front();
                if (id_instr === e.instr && id_pc_plus4 === e.pc_plus4) begin
                    passes++;
                    $display("txn %0d: pc_plus4=0x%08h instr=0x%08h ok", txn_n, id_pc_plus4, id_instr);
                end else begin
                    $display("FAIL txn %0d: got pc_plus4=0x%08h instr=0x%08h, expected pc_plus4=0x%08h instr=0x%08h",
                             txn_n, id_pc_plus4, id_instr, e.pc_plus4, e.instr);
                end
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        id_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset state
        tick();
        chk("reset id_valid", 32'(id_valid), 32'd0);
        chk("reset id_instr", id_instr, 32'h0);
        chk("reset id_pc_plus4", id_pc_plus4, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);
        tick();
        rst_n = 1'b1;

        // Free run with id_ready=1
        chk("run imem_addr 0", imem_addr, 32'h0);
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        expect_fetch(32'hC);
        expect_fetch(32'h10);
        tick();
        chk("first id_valid", 32'(id_valid), 32'd1);
        chk("first id_instr", id_instr, 32'h2008_0001);
        chk("first id_pc_plus4", id_pc_plus4, 32'h4);
        chk("run imem_addr 4", imem_addr, 32'h4);
        tick();
        chk("run imem_addr 8", imem_addr, 32'h8);
        tick();
        chk("run imem_addr C", imem_addr, 32'hC);

        // Stall for 5 cycles: entries 8 and C fill the queue, PC holds at 0x10
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall imem_addr", imem_addr, 32'h10);
            chk("stall id_instr", id_instr, imem_word(32'h8));
        end
        id_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("drain imem_addr", imem_addr, 32'h1C);

        // Redirect while full and stalled
        id_ready = 1'b0;
        tick();
        tick();
        chk("full hold imem_addr", imem_addr, 32'h1C);
        chk("full hold id_valid", 32'(id_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("redirect id_valid", 32'(id_valid), 32'd0);
        chk("redirect imem_addr", imem_addr, 32'h40);
        expect_fetch(32'h40);
        tick();
        chk("target id_valid", 32'(id_valid), 32'd1);
        chk("target id_pc_plus4", id_pc_plus4, 32'h44);
        chk("target id_instr", id_instr, imem_word(32'h40));

        // Unaligned redirect while decode is accepting: the head pop is discarded
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h47;
        tick();
        redirect_valid = 1'b0;
        chk("unaligned imem_addr", imem_addr, 32'h44);
        chk("unaligned id_valid", 32'(id_valid), 32'd0);
        expect_fetch(32'h44);
        tick();
        chk("unaligned id_pc_plus4", id_pc_plus4, 32'h48);
        tick();

        // Wrap-around at the top of the address space
        id_ready = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        expect_fetch(32'hFFFF_FFF8);
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0);
        tick();
        chk("wrap imem_addr FFFC", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap imem_addr 0", imem_addr, 32'h0);
        chk("wrap id_pc_plus4", id_pc_plus4, 32'h0);
        chk("wrap id_valid", 32'(id_valid), 32'd1);
        chk("wrap id_instr", id_instr, imem_word(32'hFFFF_FFFC));
        tick();
        tick();

        // Reset asserted mid-stall with a full queue
        id_ready = 1'b0;
        tick();
        tick();
        chk("pre-reset imem_addr", imem_addr, 32'hC);
        rst_n = 1'b0;
        tick();
        chk("mid reset id_valid", 32'(id_valid), 32'd0);
        chk("mid reset imem_addr", imem_addr, 32'h0);
        chk("mid reset id_instr", id_instr, 32'h0);
`ifdef IF_PERF_CNT_EN
        chk("reset perf_fetch_cnt", perf_fetch_cnt, 32'd0);
        chk("reset perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("post-reset hold imem_addr", imem_addr, 32'h8);
`ifdef IF_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'd2);
`endif
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        expect_fetch(32'h8);
        id_ready = 1'b1;
        tick();
        tick();
        tick();
        id_ready = 1'b0;
        tick();
        tick();

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        chk("transactions seen", 32'(txn_n), 32'd13);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
